// File: rtl/sram_access_seq.sv
// sram_access_seq: array-side access sequencer for the 256x128x8 SRAM macro.
// Turns a req/ready host handshake into a timed precharge -> wordline ->
// sense/write -> release sequence and registers read data back to the host.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req, we, addr, wdata host request; we/addr/wdata sampled with req in IDLE
//   ready                sequencer idle, request will be accepted
//   rdata, rvalid        registered read data, one-cycle valid pulse
//   wdone                one-cycle write-complete pulse
//   pre_n                bitline precharge, active low
//   wl_en, col_sel       one-hot wordline and column-mux selects
//   write_en             global write direction
//   sae                  sense-amp enable
//   col_data             shared column data bus (driven only in WRITE)
//
// state | meaning
// IDLE  | waiting for req, bitlines precharging
// PRE   | precharge for PRE_CYC cycles after accept
// WL    | wordline/column select asserted, settle WL_CYC cycles
// SENSE | sense amps enabled SENSE_CYC cycles, rdata captured on last cycle
// WRITE | column bus driven with write data WR_CYC cycles
// REL   | all selects released, precharge restarts, rvalid/wdone pulse

module sram_access_seq #(
  parameter int ROW_W     = 8,
  parameter int COL_W     = 4,
  parameter int DATA_W    = 8,
  parameter int PRE_CYC   = 2,
  parameter int WL_CYC    = 1,
  parameter int SENSE_CYC = 2,
  parameter int WR_CYC    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ROW_W+COL_W-1:0]  addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic                    ready,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic                    wdone,
  output logic                    pre_n,
  output logic [(2**ROW_W)-1:0]   wl_en,
  output logic [(2**COL_W)-1:0]   col_sel,
  output logic                    write_en,
  output logic                    sae,
  inout  wire  [DATA_W-1:0]       col_data
);

  localparam int NROW  = 2**ROW_W;
  localparam int NCOL  = 2**COL_W;
  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LD    = CNT_W'(WL_CYC - 1);
  localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(SENSE_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    WL    = 3'd2,
    SENSE = 3'd3,
    WRITE = 3'd4,
    REL   = 3'd5
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                we_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                drive;

  // Bus driver enable is its own flop so it goes high only on WRITE entry,
  // never during WL even though write_en is already set there.
  assign col_data = drive ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      wdata_q  <= '0;
      drive    <= 1'b0;
      ready    <= 1'b1;
      rdata    <= '0;
      rvalid   <= 1'b0;
      wdone    <= 1'b0;
      pre_n    <= 1'b0;
      wl_en    <= '0;
      col_sel  <= '0;
      write_en <= 1'b0;
      sae      <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      wdone  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            row_q   <= addr[ROW_W+COL_W-1:COL_W];
            col_q   <= addr[COL_W-1:0];
            wdata_q <= wdata;
            ready   <= 1'b0;
            cnt     <= PRE_LD;
            state   <= PRE;
          end
        end
        PRE: begin
          if (cnt == '0) begin
            pre_n    <= 1'b1;
            wl_en    <= {{(NROW-1){1'b0}}, 1'b1} << row_q;
            col_sel  <= {{(NCOL-1){1'b0}}, 1'b1} << col_q;
            // write_en rises together with col_sel so direction is settled
            // before any column gate opens onto a driven bus.
            write_en <= we_q;
            cnt      <= WL_LD;
            state    <= WL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WL: begin
          if (cnt == '0) begin
            if (we_q) begin
              drive <= 1'b1;
              cnt   <= WR_LD;
              state <= WRITE;
            end else begin
              sae   <= 1'b1;
              cnt   <= SENSE_LD;
              state <= SENSE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SENSE: begin
          if (cnt == '0) begin
            rdata   <= col_data;
            sae     <= 1'b0;
            pre_n   <= 1'b0;
            wl_en   <= '0;
            col_sel <= '0;
            rvalid  <= 1'b1;
            state   <= REL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE: begin
          if (cnt == '0) begin
            drive    <= 1'b0;
            write_en <= 1'b0;
            pre_n    <= 1'b0;
            wl_en    <= '0;
            col_sel  <= '0;
            wdone    <= 1'b1;
            state    <= REL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REL: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_seq.sv
// Scoreboard bench for sram_access_seq: the driver pushes the expected
// response (kind, data, cycle) when a request is accepted; a monitor pops and
// compares whenever rvalid or wdone is seen. Per-cycle array-side traces and a
// break-before-make watcher check the control waveform.

module tb_sram_access_seq;

  localparam int LAT = 6;  // accept edge to rvalid/wdone, defaults

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic         we;
  logic [11:0]  addr;
  logic [7:0]   wdata;
  logic         ready;
  logic [7:0]   rdata;
  logic         rvalid;
  logic         wdone;
  logic         pre_n;
  logic [255:0] wl_en;
  logic [15:0]  col_sel;
  logic         write_en;
  logic         sae;
  wire  [7:0]   col_data;

  // Bench side of the column bus: a keeper value of 0 everywhere except the
  // WRITE window (bench released) and while sae is high (model read data).
  logic [7:0]   rd_model;
  logic [7:0]   tb_val;
  logic         tb_oe;
  int           we_cyc;

  assign tb_val   = sae ? rd_model : 8'h00;
  assign tb_oe    = !(write_en && (we_cyc >= 1));
  assign col_data = tb_oe ? tb_val : 8'hzz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) we_cyc <= 0;
    else if (write_en) we_cyc <= we_cyc + 1;
    else we_cyc <= 0;
  end

  sram_access_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .wdone    (wdone),
    .pre_n    (pre_n),
    .wl_en    (wl_en),
    .col_sel  (col_sel),
    .write_en (write_en),
    .sae      (sae),
    .col_data (col_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && (rvalid || wdone)) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {rvalid, wdone}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_kind", {rvalid, wdone}, e.wr ? 2'b01 : 2'b10);
        chk("resp_cycle", cyc, e.cyc);
        if (!e.wr) chk("rdata", rdata, e.data);
      end
    end
  end

  // Break-before-make: between two consecutive cycles with a column selected,
  // neither the selected column nor write_en may change.
  logic [15:0] prev_cs = '0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (prev_cs != 0 && col_sel != 0) begin
      chk("bbm_write_en", write_en, prev_we);
      chk("bbm_col_sel", col_sel, prev_cs);
    end
    prev_cs = col_sel;
    prev_we = write_en;
  end

  // Call only at a negedge or shortly after a posedge (ready stable).
  task automatic issue(input bit wr, input logic [11:0] a, input logic [7:0] d,
                       input logic [7:0] rd_exp, input bit hold, output int acc);
    int budget;
    bit r;
    exp_t e;
    budget = 0;
    req = 1'b1; we = wr; addr = a; wdata = d;
    forever begin
      r = ready;
      @(posedge clk);
      if (r || budget > 50) break;
      budget++;
      @(negedge clk);
    end
    chk("accept_timeout", budget > 50, 1'b0);
    #1;
    acc   = cyc;
    e.wr  = wr;
    e.data = rd_exp;
    // Response is high during the LAT-th cycle, the accept cycle being first.
    e.cyc = acc + LAT - 1;
    sb.push_back(e);
    if (!hold) req = 1'b0;
  endtask

  // Cycle-by-cycle array-side waveform following an accept.
  task automatic trace(input bit wr, input logic [11:0] a, input logic [7:0] wd,
                       input logic [7:0] rd, input int ncyc);
    for (int i = 1; i <= ncyc; i++) begin
      bit act;
      bit mid;
      @(negedge clk);
      act = (i >= 3) && (i <= 5);
      mid = (i == 4) || (i == 5);
      chk("tr_pre_n", pre_n, act);
      chk("tr_wl_en", wl_en, act ? (256'd1 << a[11:4]) : 256'd0);
      chk("tr_col_sel", col_sel, act ? (16'd1 << a[3:0]) : 16'd0);
      chk("tr_write_en", write_en, act && wr);
      chk("tr_sae", sae, mid && !wr);
      chk("tr_ready", ready, i >= 7);
      chk("tr_col_data", col_data, mid ? (wr ? wd : rd) : 8'h00);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_pre_n"}, pre_n, 1'b0);
    chk({tag, "_wl_en"}, wl_en, 256'd0);
    chk({tag, "_col_sel"}, col_sel, 16'd0);
    chk({tag, "_write_en"}, write_en, 1'b0);
    chk({tag, "_sae"}, sae, 1'b0);
    chk({tag, "_resp"}, {rvalid, wdone}, 2'b00);
    chk({tag, "_col_data"}, col_data, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; rd_model = 8'h00;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("idle");

    // Reset asserted while idle
    rst_n = 1'b0;
    #1 chk_idle("rst_idle");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 3A5 <- C3
    issue(1'b1, 12'h3A5, 8'hC3, 8'h00, 1'b0, a1);
    trace(1'b1, 12'h3A5, 8'hC3, 8'h00, 7);

    // Read 3A5, bus model returns C3
    rd_model = 8'hC3;
    issue(1'b0, 12'h3A5, 8'h00, 8'hC3, 1'b0, a1);
    trace(1'b0, 12'h3A5, 8'h00, 8'hC3, 7);

    // Back-to-back with req held: write FFF <- 5A then read 000
    rd_model = 8'h3C;
    issue(1'b1, 12'hFFF, 8'h5A, 8'h00, 1'b1, a1);
    issue(1'b0, 12'h000, 8'h00, 8'h3C, 1'b0, a2);
    chk("b2b_spacing", a2 - a1, LAT + 1);
    repeat (8) @(negedge clk);
    chk("b2b_ready", ready, 1'b1);

    // Busy ignore: new request pulsed during SENSE
    rd_model = 8'h7E;
    issue(1'b0, 12'h3A5, 8'h00, 8'h7E, 1'b0, a3);
    fork
      trace(1'b0, 12'h3A5, 8'h00, 8'h7E, 7);
      begin
        repeat (4) @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 12'h000; wdata = 8'hEE;
        @(negedge clk);
        req = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    chk("busy_still_idle", {ready, pre_n, write_en}, 3'b100);

    // Reset during the second WRITE cycle
    rd_model = 8'h00;
    issue(1'b1, 12'h123, 8'h99, 8'h00, 1'b0, a1);
    repeat (5) @(negedge clk);
    chk("mr_col_data_drv", col_data, 8'h99);
    chk("mr_write_en_drv", write_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk_idle("mr");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_model = 8'hA7;
    issue(1'b0, 12'h123, 8'h00, 8'hA7, 1'b0, a1);
    trace(1'b0, 12'h123, 8'h00, 8'hA7, 7);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_access_seq.md
Name: sram_access_seq

Overview:
Access sequencer for the 256x128x8 SRAM macro. Owns the array-side control that the column transmission gates consume.
- Drives precharge, the one-hot wordline, the one-hot column-mux select, the global write_en, sense-amp enable and the shared 8-bit column data bus.
- Converts a simple req/ready host handshake into a timed precharge → wordline → sense/write → release sequence.
- Registers read data back to the host.

Parameters:
ROW_W, 8, row address width (256 wordlines)
COL_W, 4, column-word address width (16 words of 8 bits per 128-bit row)
DATA_W, 8, word width
PRE_CYC, 2, precharge cycles (≥1)
WL_CYC, 1, wordline settle cycles before sense/write (≥1)
SENSE_CYC, 2, sense-amp enable cycles (≥1)
WR_CYC, 2, write-drive cycles (≥1)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  host access request
we  input  1  1=write, 0=read; sampled with req
addr  input  ROW_W+COL_W  {row, col}; sampled with req
wdata  input  DATA_W  write data; sampled with req
ready  output  1  sequencer idle, can accept req
rdata  output  DATA_W  registered read data
rvalid  output  1  one-cycle pulse, rdata valid
wdone  output  1  one-cycle pulse, write complete
pre_n  output  1  bitline precharge, active low
wl_en  output  2**ROW_W  one-hot wordline enable
col_sel  output  2**COL_W  one-hot column-mux select (drives gate S inputs)
write_en  output  1  global direction: 1 = write toward cells
sae  output  1  sense-amp enable
col_data  inout  DATA_W  shared column data bus

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - ready=1, pre_n=0 (precharging), wl_en=0, col_sel=0, write_en=0, sae=0, rvalid=0, wdone=0, rdata=0, col_data released (Z).
- Accept: in IDLE, req=1 at a rising edge captures we/addr/wdata into registers and sets ready=0 next cycle. Inputs are ignored while ready=0; the host need not hold req.
- FSM states: IDLE, PRE, WL, SENSE, WRITE, REL.
  - IDLE→PRE on accept.
  - PRE: pre_n=0 for PRE_CYC cycles → WL.
  - WL: pre_n=1; wl_en[row] and col_sel[col] asserted, one-hot; for a write, write_en=1 from WL entry. Hold WL_CYC cycles → SENSE if read, WRITE if write.
  - SENSE: sae=1, wl_en/col_sel held for SENSE_CYC cycles. On the final SENSE cycle col_data is sampled into rdata. → REL.
  - WRITE: write_en=1; col_data driven with captured wdata; wl_en/col_sel held for WR_CYC cycles. → REL.
  - REL (1 cycle): wl_en=0, col_sel=0, sae=0, write_en=0, col_data=Z, pre_n=0. rvalid (read) or wdone (write) pulses high this cycle. → IDLE with ready=1 next cycle.
- Break-before-make:
  - write_en must never change while any col_sel bit is 1 except at WL entry/REL exit edges, where col_sel and write_en transition together from/to 0.
  - col_data is driven only when state=WRITE; it must be Z in all other states, including WL of a write.
- Latency, accept edge to rvalid/wdone high:
  - read = PRE_CYC+WL_CYC+SENSE_CYC+1 (defaults: 6)
  - write = PRE_CYC+WL_CYC+WR_CYC+1 (defaults: 6)
- Back-to-back: req held high in IDLE is accepted on the cycle ready returns to 1. Minimum spacing = latency+1.
- Addressing: all 2**ROW_W × 2**COL_W addresses are valid. No wrap or overflow case exists. Exactly one wl_en bit and one col_sel bit are active during WL/SENSE/WRITE; all bits are 0 otherwise.
- Read of X/Z bus: rdata stores the sampled value unmodified. No error flag.
- Reset mid-operation: all outputs return asynchronously to reset values, col_data releases immediately, and the in-flight access is dropped with no rvalid/wdone.
- pre_n=0 in IDLE, PRE and REL; 1 in WL, SENSE, WRITE.

Test Plan:
- Reset: rst_n=0 mid-idle → ready=1, pre_n=0, wl_en=0, col_sel=0, write_en=0, sae=0, col_data=Z.
- Write: req, we=1, addr=12'h3A5, wdata=8'hC3 → wl_en[8'h3A]=1, col_sel[5]=1, write_en=1 during WL/WRITE; col_data=8'hC3 only in WRITE; wdone high exactly 6 cycles after accept; ready=1 the cycle after.
- Read: req, we=0, addr=12'h3A5, bench model drives col_data=8'hC3 while sae=1 → sae high 2 cycles; rvalid pulse 6 cycles after accept with rdata=8'hC3; write_en stays 0 throughout.
- Back-to-back: req held high for write 12'hFFF/8'h5A then read 12'h000 → second access accepted on the first ready=1 cycle; col_sel switches 15→0 via an all-zero REL cycle; write_en never 1 while col_sel[0]=1.
- Busy ignore: pulse req with new addr during SENSE → no effect; only one rvalid; captured address unchanged.
- Reset during WRITE (2nd WRITE cycle) → col_data=Z and write_en=0 immediately; no wdone; next access after release completes normally.
